instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the control unit. Owns the program counter and issues word reads to instruction memory over a req/ack handshake. Holds each returned 16-bit instruction in an instruction register and presents it to decode, split into opcode and fields, over a valid/ready handshake. Supports PC redirect (branch/jump) from downstream.

## Interface
- PC_W, 8, program counter / instruction address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  PC_W  word address of request (= PC)
- imem_rdata  in  16  instruction word, valid when imem_ack=1
- imem_ack  in  1  read complete; honoured only while imem_req=1
- out_valid  out  1  decode fields valid
- out_ready  in  1  decode accepts current instruction
- opcode  out  4  IR[15:12], feeds control unit opcode input
- rs  out  4  IR[11:8]
- rt  out  4  IR[7:4]
- imm  out  4  IR[3:0] (rd or immediate)
- pc_out  out  PC_W  address the presented instruction was fetched from
- redirect  in  1  load redirect_pc, flush fetch
- redirect_pc  in  PC_W  new PC
- illegal  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- States: IDLE, REQ, HOLD, (STOP when FETCH_ILLEGAL_CHK_EN).
- IDLE: entered on reset; unconditionally -> REQ next cycle.
- REQ: imem_req=1, imem_addr=PC. On imem_ack: IR<=imem_rdata, pc_out<=PC, PC<=PC+1 mod 2^PC_W, -> HOLD. No ack: stay, address stable.
- HOLD: out_valid=1, fields driven from IR, stable. out_valid&out_ready -> REQ. Otherwise stay.
- Redirect (any state) has top priority: PC<=redirect_pc, out_valid cleared, pending request abandoned (same-cycle imem_ack discarded, IR unchanged), -> REQ. illegal cleared.
- imem_req and out_valid are decoded from the state register only (no combinational path from imem_ack/out_ready).
- Memory must tolerate a request withdrawn by redirect; a late ack while imem_req=0 is ignored.

## Timing
- Reset (async assert): state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, out_valid=0, opcode/rs/rt/imm=0, pc_out=0, illegal=0.
- First imem_req: second rising edge after rst_n deasserts (IDLE one cycle).
- Ack sampled at edge N -> out_valid=1 from cycle N+1.
- Accept at edge M -> imem_req=1 from cycle M+1 with incremented address.
- Peak throughput: one instruction per 2 cycles (zero-wait ack, ready held high).
- PC wrap: PC=2^PC_W-1 fetches, next PC=0; no flag.
- Redirect with simultaneous handshake accept: accept counts (instruction consumed), redirect still applies.
- Reset mid-request: request dropped immediately, no IR update.

## Configuration
- FETCH_ILLEGAL_CHK_EN defined: on ack, opcode outside {0000,0001,0010,0011,0111,1111} (the set the control unit decodes) -> IR not presented, out_valid stays 0, illegal=1, state STOP; imem_req=0 in STOP; only redirect or reset exits (-> REQ, illegal cleared). PC still increments on the illegal fetch.
- Undefined: all opcodes passed through to HOLD; illegal tied 0; STOP absent.

## Test plan
- Reset with RESET_PC=8'h10: all outputs at reset values; imem_req=1 with imem_addr=8'h10 on 2nd edge after release.
- Zero-wait memory returning 16'h1234,16'h0567,16'h2ABC at 0x10-0x12, out_ready=1 -> opcodes 1,0,2 with pc_out 0x10,0x11,0x12; one instruction every 2 cycles.
- ack delayed 3 cycles, out_ready low 5 cycles in HOLD -> imem_addr stable during wait, fields stable, no new req until accept.
- redirect to 0x40 same cycle as imem_ack for 0x13 -> ack discarded, out_valid stays 0, next imem_addr=0x40.
- PC=0xFF fetch of 16'h7123 -> pc_out=0xFF, next imem_addr=0x00.
- With FETCH_ILLEGAL_CHK_EN, fetch 16'h5000 -> illegal=1, out_valid=0, imem_req=0 until redirect to 0x20, then illegal=0 and req at 0x20; without macro, opcode 5 presented normally.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem req/ack, IR to decode valid/ready
// Optional feature macro: FETCH_ILLEGAL_CHK_EN (illegal-opcode trap into STOP state)
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      opcode,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [3:0]      imm,
  output logic [PC_W-1:0] pc_out,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            illegal
);

`ifdef FETCH_ILLEGAL_CHK_EN
  typedef enum logic [1:0] {IDLE, REQ, HOLD, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic [15:0]     ir_q, ir_d;
  logic            trap;

`ifdef FETCH_ILLEGAL_CHK_EN
  logic illegal_q, illegal_d;

  // Only the opcodes the control unit actually decodes are let through.
  always_comb begin
    case (imem_rdata[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hF: trap = 1'b0;
      default:                            trap = 1'b1;
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
`ifdef FETCH_ILLEGAL_CHK_EN
    illegal_d = illegal_q;
`endif
    if (redirect) begin
      // Redirect wins over everything, including a same-cycle ack.
      pc_d    = redirect_pc;
      state_d = REQ;
`ifdef FETCH_ILLEGAL_CHK_EN
      illegal_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            pc_d = pc_q + PC_W'(1);
            if (trap) begin
`ifdef FETCH_ILLEGAL_CHK_EN
              illegal_d = 1'b1;
              state_d   = STOP;
`endif
            end else begin
              ir_d     = imem_rdata;
              pc_out_d = pc_q;
              state_d  = HOLD;
            end
          end
        end
        HOLD: if (out_ready) state_d = REQ;
`ifdef FETCH_ILLEGAL_CHK_EN
        STOP: state_d = STOP;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      ir_q     <= '0;
`ifdef FETCH_ILLEGAL_CHK_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
`ifdef FETCH_ILLEGAL_CHK_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign imem_req  = (state_q == REQ);
  assign out_valid = (state_q == HOLD);
  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign opcode    = ir_q[15:12];
  assign rs        = ir_q[11:8];
  assign rt        = ir_q[7:4];
  assign imm       = ir_q[3:0];
`ifdef FETCH_ILLEGAL_CHK_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a fetch-sequence model
module tb_instr_fetch;
  localparam int         PC_W   = 8;
  localparam logic [7:0] RST_PC = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode, rs, rt, imm;
  logic [7:0]  pc_out;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        illegal;

  logic [15:0] mem [256];

  int errors = 0;
  int checks = 0;

  // Reference model: the address of the next fetch, and the instruction currently held.
  bit          m_idle, m_req, m_valid, m_ill;
  logic [7:0]  m_next, m_ppc;
  logic [15:0] m_pword;

  instr_fetch #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .imm(imm), .pc_out(pc_out),
    .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit decodable(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hF};
  endfunction

  task automatic model_reset();
    m_idle = 1; m_req = 0; m_valid = 0; m_ill = 0;
    m_next = RST_PC; m_ppc = 8'h00; m_pword = 16'h0000;
  endtask

  task automatic check_outputs();
    check("imem_req",  32'(imem_req),  32'(m_req));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("illegal",   32'(illegal),   32'(m_ill));
    check("imem_addr", 32'(imem_addr), 32'(m_next));
    check("fields",    32'({opcode, rs, rt, imm}), 32'(m_pword));
    check("pc_out",    32'(pc_out),    32'(m_ppc));
  endtask

  // Check the settled outputs, apply inputs for the next edge, advance the model, move to next negedge.
  task automatic cycle(input bit ack, input bit ready, input bit redir, input logic [7:0] rpc);
    logic [15:0] w;
    bit bad;
    check_outputs();
    imem_ack = ack; out_ready = ready; redirect = redir; redirect_pc = rpc;
    if (redir) begin
      m_idle = 0; m_next = rpc; m_req = 1; m_valid = 0; m_ill = 0;
    end else if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (m_req && ack) begin
      w = mem[m_next];
`ifdef FETCH_ILLEGAL_CHK_EN
      bad = !decodable(w[15:12]);
`else
      bad = 0;
`endif
      m_req = 0;
      if (bad) m_ill = 1;
      else begin
        m_pword = w; m_ppc = m_next; m_valid = 1;
      end
      m_next = m_next + 8'h01;
    end else if (m_valid && ready) begin
      m_valid = 0; m_req = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    bit a, r, d;
    logic [7:0] p;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'h1234; mem[8'h11] = 16'h0567; mem[8'h12] = 16'h2ABC;
    mem[8'h13] = 16'h3111; mem[8'h40] = 16'h3456; mem[8'h41] = 16'h7EEE;
    mem[8'hFF] = 16'h7123; mem[8'h00] = 16'h5000; mem[8'h20] = 16'h1020;

    rst_n = 0; imem_ack = 0; out_ready = 0; redirect = 0; redirect_pc = 0;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1;

    cycle(0, 0, 0, 0);
    check("first_req", 32'(imem_req), 32'd1);
    repeat (6) cycle(1, 1, 0, 0);
    // Redirect coinciding with the ack for 0x13: the returned word must be dropped.
    cycle(1, 0, 1, 8'h40);
    check("redir_no_valid", 32'(out_valid), 32'd0);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 8'hFF);
    cycle(1, 0, 0, 0);
    check("wrap_pc_out", 32'(pc_out), 32'h0FF);
    check("wrap_addr", 32'(imem_addr), 32'h000);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
`ifdef FETCH_ILLEGAL_CHK_EN
    check("illegal_set", 32'(illegal), 32'd1);
    repeat (4) cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 8'h20);
    check("illegal_clr", 32'(illegal), 32'd0);
`else
    check("op5_passed", 32'(opcode), 32'h5);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 8'h20);
`endif
    check("redir_addr", 32'(imem_addr), 32'h020);

    for (int n = 0; n < 500; n++) begin
      a = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 9) < 6);
      d = ($urandom_range(0, 19) == 0);
      p = 8'($urandom);
      cycle(a, r, d, p);
    end

    // Asynchronous reset landing between edges while a request is outstanding.
    while (!imem_req) cycle(0, 1, 0, 0);
    imem_ack = 1;
    #2 rst_n = 0;
    #1 check("async_req_drop", 32'(imem_req), 32'd0);
    check("async_addr", 32'(imem_addr), 32'(RST_PC));
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1;
    imem_ack = 0;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 9) < 7);
      cycle(a, r, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
